// File: rtl/wavdec_pkg.sv
// Shared elaboration-time helpers for the wavelet decomposition stage:
// coefficient unpacking, QMF derivation and derived widths/latencies.
package wavdec_pkg;

    localparam int MAX_HBITS = 4096;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Sign-extends coefficient idx of a packed width-bit coefficient vector.
    function automatic logic signed [63:0] coef_extract(input logic [MAX_HBITS-1:0] vec,
                                                        input int idx, input int width);
        logic [MAX_HBITS-1:0] tmp;
        logic signed [63:0]   c;
        tmp = vec >> (idx * width);
        c   = signed'(tmp[63:0]);
        c   = c <<< (64 - width);
        return c >>> (64 - width);
    endfunction

    // Highpass tap k from the lowpass set: g[k] = (-1)^k * h[TAPS-1-k].
    function automatic logic signed [63:0] qmf_coef(input logic [MAX_HBITS-1:0] vec,
                                                    input int k, input int taps, input int width);
        logic signed [63:0] h;
        h = coef_extract(vec, taps - 1 - k, width);
        return (k % 2 == 1) ? -h : h;
    endfunction

    function automatic int calc_shift(input int in_frac, input int coef_frac, input int out_frac);
        return in_frac + coef_frac - out_frac;
    endfunction

    function automatic int calc_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    function automatic int calc_warm_beats(input int taps, input int n_in);
        return (taps - 1 + n_in - 1) / n_in;
    endfunction

endpackage

// File: rtl/wavelet_dec_stage_round_sat.sv
// Per-lane round-half-up and clamp from the accumulator format to the output format.
module wavdec_round_sat #(
    parameter int ACC_W     = 44,
    parameter int SHIFT     = 0,
    parameter int OUT_WIDTH = 48
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [OUT_WIDTH-1:0]    value_o,
    output logic                    sat_o
);

    // Wide enough for the rounding add, the shifted range and both clamp limits.
    localparam int EW0 = (ACC_W + 1 > OUT_WIDTH) ? ACC_W + 1 : OUT_WIDTH;
    localparam int EW  = ((EW0 > SHIFT + 1) ? EW0 : SHIFT + 1) + 1;
    localparam logic signed [EW-1:0] ONE   = 1;
    localparam logic signed [EW-1:0] MAX_V = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [EW-1:0] MIN_V = -(ONE <<< (OUT_WIDTH - 1));

    logic signed [EW-1:0] acc_ext;
    logic signed [EW-1:0] shifted;

    assign acc_ext = {{(EW - ACC_W){acc_i[ACC_W-1]}}, acc_i};

    if (SHIFT > 0) begin : g_round
        localparam logic signed [EW-1:0] HALF = ONE <<< (SHIFT - 1);
        assign shifted = (acc_ext + HALF) >>> SHIFT;
    end else begin : g_pass
        assign shifted = acc_ext;
    end

    always_comb begin
        sat_o   = 1'b0;
        value_o = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            value_o = MAX_V[OUT_WIDTH-1:0];
            sat_o   = 1'b1;
        end else if (shifted < MIN_V) begin
            value_o = MIN_V[OUT_WIDTH-1:0];
            sat_o   = 1'b1;
        end
    end

endmodule

// File: rtl/wavelet_dec_stage.sv
// Polyphase single-level wavelet decomposition stage (multiply / sum / round-sat pipeline).
// Build with WAVDEC_DETAIL_EN defined to include the QMF detail branch; otherwise d_out is 0.
module wavelet_dec_stage
    import wavdec_pkg::*;
#(
    parameter int N_IN       = 16,
    parameter int TAPS       = 8,
    parameter int DATA_WIDTH = 16,
    parameter int IN_FRAC    = 0,
    parameter int COEF_WIDTH = 25,
    parameter int COEF_FRAC  = 23,
    parameter logic [TAPS*COEF_WIDTH-1:0] H_COEFS = '0,
    parameter int OUT_WIDTH  = 48,
    parameter int OUT_FRAC   = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            din_valid,
    input  logic [N_IN*DATA_WIDTH-1:0]      din,
    output logic                            dout_valid,
    output logic [(N_IN/2)*OUT_WIDTH-1:0]   a_out,
    output logic [(N_IN/2)*OUT_WIDTH-1:0]   d_out,
    output logic                            sat,
    output logic                            warm
);

    localparam int HALF_N     = N_IN / 2;
    localparam int HIST       = TAPS - 1;
    localparam int PROD_W     = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W      = calc_acc_w(DATA_WIDTH, COEF_WIDTH, TAPS);
    localparam int SHIFT      = calc_shift(IN_FRAC, COEF_FRAC, OUT_FRAC);
    localparam int WARM_BEATS = calc_warm_beats(TAPS, N_IN);
    localparam int CNT_W      = clog2(WARM_BEATS + 1) + 1;
    localparam logic [CNT_W-1:0]     WARM_C = CNT_W'(WARM_BEATS);
    localparam logic [MAX_HBITS-1:0] H_EXT  = MAX_HBITS'(H_COEFS);

    if (N_IN % 2 != 0) begin : g_err_nin
        $error("wavelet_dec_stage: N_IN must be even");
    end
    if (TAPS % 2 != 0) begin : g_err_taps
        $error("wavelet_dec_stage: TAPS must be even");
    end
    if (SHIFT < 0) begin : g_err_frac
        $error("wavelet_dec_stage: OUT_FRAC exceeds IN_FRAC + COEF_FRAC");
    end
    if (TAPS * COEF_WIDTH > MAX_HBITS) begin : g_err_coef
        $error("wavelet_dec_stage: H_COEFS wider than supported");
    end

    genvar gi, gk;

    // Sample window: history (oldest first) followed by the current beat; x(n) = ext_w[HIST+n].
    logic signed [DATA_WIDTH-1:0] ext_w [HIST + N_IN];

    for (gi = 0; gi < N_IN; gi++) begin : g_din
        assign ext_w[HIST + gi] = din[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    for (gi = 0; gi < HIST; gi++) begin : g_hist
        logic signed [DATA_WIDTH-1:0] hist_q;
        always_ff @(posedge clk) begin
            if (rst || clear)  hist_q <= '0;
            else if (din_valid) hist_q <= ext_w[N_IN + gi];
        end
        assign ext_w[gi] = hist_q;
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_w;
    logic             v1_q, v2_q;

    always_comb begin
        cnt_d = cnt_q;
        if (din_valid && cnt_q != WARM_C) cnt_d = cnt_q + 1'b1;
    end

    assign accept_w = din_valid && !clear && (cnt_q == WARM_C);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v1_q  <= accept_w;
            v2_q  <= v1_q;
        end
    end

    logic [HALF_N*OUT_WIDTH-1:0] ra_all, rd_all;
    logic [HALF_N-1:0]           sat_a_w, sat_d_w;

    for (gi = 0; gi < HALF_N; gi++) begin : g_lane
        logic signed [ACC_W-1:0] psum_a_w [TAPS + 1];
        logic signed [ACC_W-1:0] acc_a_q;
        assign psum_a_w[0] = '0;
`ifdef WAVDEC_DETAIL_EN
        logic signed [ACC_W-1:0] psum_d_w [TAPS + 1];
        logic signed [ACC_W-1:0] acc_d_q;
        assign psum_d_w[0] = '0;
`endif
        for (gk = 0; gk < TAPS; gk++) begin : g_tap
            localparam logic signed [PROD_W-1:0] H_K = PROD_W'(coef_extract(H_EXT, gk, COEF_WIDTH));
            logic signed [PROD_W-1:0] prod_a_q;
            always_ff @(posedge clk) prod_a_q <= PROD_W'(ext_w[HIST + 2*gi - gk]) * H_K;
            assign psum_a_w[gk + 1] = psum_a_w[gk] + ACC_W'(prod_a_q);
`ifdef WAVDEC_DETAIL_EN
            localparam logic signed [PROD_W-1:0] G_K = PROD_W'(qmf_coef(H_EXT, gk, TAPS, COEF_WIDTH));
            logic signed [PROD_W-1:0] prod_d_q;
            always_ff @(posedge clk) prod_d_q <= PROD_W'(ext_w[HIST + 2*gi - gk]) * G_K;
            assign psum_d_w[gk + 1] = psum_d_w[gk] + ACC_W'(prod_d_q);
`endif
        end

        always_ff @(posedge clk) acc_a_q <= psum_a_w[TAPS];

        wavdec_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) u_rs_a (
            .acc_i   (acc_a_q),
            .value_o (ra_all[gi*OUT_WIDTH +: OUT_WIDTH]),
            .sat_o   (sat_a_w[gi])
        );
`ifdef WAVDEC_DETAIL_EN
        always_ff @(posedge clk) acc_d_q <= psum_d_w[TAPS];

        wavdec_round_sat #(.ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)) u_rs_d (
            .acc_i   (acc_d_q),
            .value_o (rd_all[gi*OUT_WIDTH +: OUT_WIDTH]),
            .sat_o   (sat_d_w[gi])
        );
`else
        assign rd_all[gi*OUT_WIDTH +: OUT_WIDTH] = '0;
        assign sat_d_w[gi] = 1'b0;
`endif
    end

    logic                        dv_q, sat_q;
    logic [HALF_N*OUT_WIDTH-1:0] a_q, d_q;

    // Clear drops in-flight beats but leaves the last published coefficients in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q  <= 1'b0;
            sat_q <= 1'b0;
            a_q   <= '0;
            d_q   <= '0;
        end else if (clear) begin
            dv_q  <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            dv_q  <= v2_q;
            sat_q <= v2_q && (|sat_a_w || |sat_d_w);
            if (v2_q) begin
                a_q <= ra_all;
                d_q <= rd_all;
            end
        end
    end

    assign dout_valid = dv_q;
    assign sat        = sat_q;
    assign a_out      = a_q;
    assign d_out      = d_q;
    assign warm       = (cnt_q == WARM_C);

endmodule

// File: tb/tb_wavelet_dec_stage.sv
// Directed self-checking bench: impulse, gapped stream, clear/reset, warm-up, DC and round/saturate.
module tb_wavelet_dec_stage;

`ifdef WAVDEC_DETAIL_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif
    localparam longint S = 64'sd8388608;

    logic clk;
    int   n_checks;
    int   n_fail;

    // Instance A: defaults, identity lowpass (h0 = 1.0)
    logic         rst_a, clr_a, v_a, dv_a, sat_a, warm_a;
    logic [255:0] din_a;
    logic [383:0] ao_a, do_a;
    // Instance W: 4 lanes, 8 taps, h = 0.125 everywhere
    logic         rst_w, clr_w, v_w, dv_w, sat_w, warm_w;
    logic [63:0]  din_w;
    logic [95:0]  ao_w, do_w;
    // Instance R: 2 lanes, 2 taps, h = {1.5, 0.5}, 16-bit integer output
    logic         rst_r, clr_r, v_r, dv_r, sat_r, warm_r;
    logic [31:0]  din_r;
    logic [15:0]  ao_r, do_r;

    wavelet_dec_stage #(.H_COEFS(200'd8388608)) u_a (
        .clk(clk), .rst(rst_a), .clear(clr_a), .din_valid(v_a), .din(din_a),
        .dout_valid(dv_a), .a_out(ao_a), .d_out(do_a), .sat(sat_a), .warm(warm_a)
    );

    wavelet_dec_stage #(.N_IN(4), .TAPS(8), .H_COEFS({8{25'd1048576}})) u_w (
        .clk(clk), .rst(rst_w), .clear(clr_w), .din_valid(v_w), .din(din_w),
        .dout_valid(dv_w), .a_out(ao_w), .d_out(do_w), .sat(sat_w), .warm(warm_w)
    );

    wavelet_dec_stage #(.N_IN(2), .TAPS(2), .H_COEFS({25'd4194304, 25'd12582912}),
                        .OUT_WIDTH(16), .OUT_FRAC(0)) u_r (
        .clk(clk), .rst(rst_r), .clear(clr_r), .din_valid(v_r), .din(din_r),
        .dout_valid(dv_r), .a_out(ao_r), .d_out(do_r), .sat(sat_r), .warm(warm_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [383:0] vec, input int j, input int w);
        logic [383:0] t;
        longint       c;
        t = vec >> (j * w);
        c = longint'(t[63:0]);
        c = c <<< (64 - w);
        return c >>> (64 - w);
    endfunction

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = r | (256'(16'(base + i)) << (i * 16));
        return r;
    endfunction

    initial begin
        bit  gv [4];
        int  gb [4];
        int  ed0 [4];
        n_checks = 0;
        n_fail   = 0;
        gv  = '{1'b1, 1'b0, 1'b1, 1'b1};
        gb  = '{10, 0, 20, 30};
        ed0 = '{0, 0, -19, -29};
        {rst_a, rst_w, rst_r} = 3'b111;
        {clr_a, clr_w, clr_r} = 3'b000;
        {v_a, v_w, v_r}       = 3'b000;
        din_a = '0; din_w = '0; din_r = '0;
        tick(); tick();
        check("rst_dv",   dv_a, 0);
        check("rst_aout", longint'(ao_a == '0), 1);
        check("rst_dout", longint'(do_a == '0), 1);
        check("rst_sat",  sat_a, 0);
        check("rst_warm", warm_a, 0);
        check("rst_warm_w", warm_w, 0);
        {rst_a, rst_w, rst_r} = 3'b000;

        // Impulse: first beat only primes history
        v_a = 1'b1; din_a = 256'd100; tick();
        check("imp_warm", warm_a, 1);
        v_a = 1'b0; din_a = '0; tick(); tick();
        check("imp_no_out", dv_a, 0);
        tick();
        v_a = 1'b1; tick(); v_a = 1'b0; tick(); tick();
        $display("A impulse beat2: dv=%0b a0=%0d", dv_a, lane(ao_a, 0, 48));
        check("imp2_dv", dv_a, 1);
        check("imp2_a0", lane(ao_a, 0, 48), 0);
        check("imp2_a7", lane(ao_a, 7, 48), 0);
        v_a = 1'b1; din_a = 256'd5 << 32; tick(); v_a = 1'b0; din_a = '0; tick(); tick();
        $display("A impulse beat3: dv=%0b a1=%0d", dv_a, lane(ao_a, 1, 48));
        check("imp3_dv", dv_a, 1);
        check("imp3_a1", lane(ao_a, 1, 48), 5 * S);
        check("imp3_a0", lane(ao_a, 0, 48), 0);
        check("imp3_a2", lane(ao_a, 2, 48), 0);
        check("imp3_d1", lane(do_a, 1, 48), 0);

        // Gapped stream 1,0,1,1
        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                v_a = gv[t]; din_a = ramp(gb[t]);
            end else begin
                v_a = 1'b0;
            end
            tick();
            if (t >= 2) begin
                check("gap_dv", dv_a, longint'(gv[t-2]));
                if (gv[t-2]) begin
                    $display("A gap out base=%0d: a0=%0d d0=%0d", gb[t-2], lane(ao_a, 0, 48), lane(do_a, 0, 48));
                    check("gap_a0", lane(ao_a, 0, 48), gb[t-2] * S);
                    check("gap_a7", lane(ao_a, 7, 48), (gb[t-2] + 14) * S);
                    check("gap_d0", lane(do_a, 0, 48), DET ? ed0[t-2] * S : 0);
                    check("gap_d7", lane(do_a, 7, 48), DET ? -(gb[t-2] + 7) * S : 0);
                end
            end else begin
                check("gap_idle", dv_a, 0);
            end
        end
        v_a = 1'b0;

        // Clear in the cycle after a valid beat, colliding with another beat
        v_a = 1'b1; din_a = ramp(40); tick();
        clr_a = 1'b1; din_a = ramp(50); tick();
        clr_a = 1'b0; v_a = 1'b0;
        check("clr_dv",   dv_a, 0);
        check("clr_warm", warm_a, 0);
        check("clr_hold", lane(ao_a, 0, 48), 30 * S);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_flush", dv_a, 0);
        end
        v_a = 1'b1; din_a = ramp(60); tick(); v_a = 1'b0;
        check("clr_rewarm", warm_a, 1);
        tick(); tick();
        check("clr_suppress", dv_a, 0);
        v_a = 1'b1; din_a = ramp(70); tick(); v_a = 1'b0; tick(); tick();
        $display("A post-clear out: dv=%0b a0=%0d d0=%0d", dv_a, lane(ao_a, 0, 48), lane(do_a, 0, 48));
        check("clr_resume_dv", dv_a, 1);
        check("clr_resume_a0", lane(ao_a, 0, 48), 70 * S);
        check("clr_resume_d0", lane(do_a, 0, 48), DET ? -69 * S : 0);

        // Reset mid-stream
        v_a = 1'b1; din_a = ramp(80); tick();
        rst_a = 1'b1; din_a = ramp(90); tick();
        rst_a = 1'b0; v_a = 1'b0;
        check("mrst_dv",   dv_a, 0);
        check("mrst_aout", longint'(ao_a == '0), 1);
        check("mrst_dout", longint'(do_a == '0), 1);
        check("mrst_sat",  sat_a, 0);
        check("mrst_warm", warm_a, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_flush", dv_a, 0);
        end

        // Warm-up over two beats, then DC response
        for (int t = 0; t < 6; t++) begin
            v_w = (t < 3); din_w = {4{16'd1000}};
            tick();
            check("w_warm", warm_w, longint'(t >= 1));
            check("w_dv", dv_w, longint'(t == 4));
            if (t == 4) begin
                $display("W dc out: a0=%0d a1=%0d d0=%0d", lane(384'(ao_w), 0, 48), lane(384'(ao_w), 1, 48), lane(384'(do_w), 0, 48));
                check("dc_a0", lane(384'(ao_w), 0, 48), 64'sd8388608000);
                check("dc_a1", lane(384'(ao_w), 1, 48), 64'sd8388608000);
                check("dc_d0", lane(384'(do_w), 0, 48), 0);
                check("dc_d1", lane(384'(do_w), 1, 48), 0);
                check("dc_sat", sat_w, 0);
            end
        end
        v_w = 1'b0;

        // Round half up and saturation
        for (int t = 0; t < 6; t++) begin
            v_r = (t < 3);
            din_r = (t == 1) ? {16'hFFFD, 16'h7FFF} : 32'd0;
            tick();
            check("r_dv", dv_r, longint'(t == 3 || t == 4));
            if (t == 3) begin
                $display("R out: a=%0d d=%0d sat=%0b", lane(384'(ao_r), 0, 16), lane(384'(do_r), 0, 16), sat_r);
                check("r_clamp", lane(384'(ao_r), 0, 16), 32767);
                check("r_sat1",  sat_r, 1);
                check("r_d_rnd", lane(384'(do_r), 0, 16), DET ? 16384 : 0);
            end
            if (t == 4) begin
                $display("R out: a=%0d d=%0d sat=%0b", lane(384'(ao_r), 0, 16), lane(384'(do_r), 0, 16), sat_r);
                check("r_half_up", lane(384'(ao_r), 0, 16), -1);
                check("r_sat0",    sat_r, 0);
                check("r_d_half",  lane(384'(do_r), 0, 16), DET ? 5 : 0);
            end
            if (t == 5) begin
                check("r_hold",    lane(384'(ao_r), 0, 16), -1);
                check("r_sat_idle", sat_r, 0);
            end
        end
        v_r = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
